qpsk_deframer: RTL and testbench

Receiver-side frame synchroniser for the QPSK modem. It takes demodulated I/Q dibits from the symbol-timing/clock-recovery stage and hunts for the 8-bit frame header. Once aligned, it extracts a fixed-length payload, checks it against a 1-byte checksum, and tracks lock with a flywheel. It delivers validated payload words to the display/data sink, and is the counterpart of the transmit-side framer that emits HEADER + payload + checksum.

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_hdr_window.sv | 18 +
 rtl/qpsk_deframer.sv | 189 ++++++++++++++++++
 tb/tb_qpsk_deframer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive deframer: FSM state encoding,
// default frame header and checksum width, plus a saturating increment.
package qpsk_pkg;

   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      PAYLOAD  = 2'd1,
      CHKSUM   = 2'd2,
      HDR_SLOT = 2'd3
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hCC;
   localparam int         CHK_W          = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/qpsk_hdr_window.sv
// Dual-alignment header comparator. A dibit may complete the header either
// on its I bit (odd alignment) or on its Q bit (even alignment); both windows
// are checked against the same header pattern in parallel.
module qpsk_hdr_window #(
   parameter logic [7:0] HEADER = 8'hCC
) (
   // Only the seven most recent history bits can reach either window.
   input  logic [6:0] sr,
   input  logic       sym_i,
   input  logic       sym_q,
   output logic       odd_match,
   output logic       even_match
);

   assign odd_match  = ({sr[6:0], sym_i} == HEADER);
   assign even_match = ({sr[5:0], sym_i, sym_q} == HEADER);

endmodule

// File: rtl/qpsk_deframer.sv
// Receive-side frame synchroniser. Consumes I/Q dibits, hunts for the frame
// header at either bit alignment, extracts the payload, verifies the byte
// checksum and keeps lock with a flywheel across corrupted header slots.
// Each dibit is processed as two sequential bit steps so byte and frame
// boundaries falling between I and Q are handled exactly.
module qpsk_deframer
   import qpsk_pkg::*;
#(
   parameter logic [7:0] HEADER        = HEADER_DEFAULT,
   parameter int         PAYLOAD_BYTES = 3,
   parameter int         MISS_MAX      = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sym_valid,
   input  logic                       sym_i,
   input  logic                       sym_q,
   output logic [PAYLOAD_BYTES*8-1:0] data_out,
   output logic                       data_valid,
   output logic                       locked,
   output logic [7:0]                 err_cnt
);

   localparam int PAY_BITS = PAYLOAD_BYTES * 8;
   localparam int CNT_W    = $clog2(PAY_BITS + 1);

   localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_BITS);
   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(8);
   localparam logic [3:0]       MISS_LIM  = 4'(MISS_MAX);

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg,   cnt_next;
   logic [7:0]           sr_reg,    sr_next;
   logic [PAY_BITS-1:0]  pay_reg,   pay_next;
   logic [CHK_W-1:0]     sum_reg,   sum_next;
   logic [3:0]           miss_reg,  miss_next;
   logic                 lock_reg,  lock_next;
   logic [7:0]           err_reg,   err_next;
   logic [PAY_BITS-1:0]  dout_reg,  dout_next;
   logic                 dv_reg,    dv_next;

   logic                 odd_match, even_match;
   logic                 bit_v, hit_v;

   qpsk_hdr_window #(
      .HEADER(HEADER)
   ) u_hdr_window (
      .sr         (sr_reg[6:0]),
      .sym_i      (sym_i),
      .sym_q      (sym_q),
      .odd_match  (odd_match),
      .even_match (even_match)
   );

   // Next-state logic: walk the I bit then the Q bit through the frame FSM.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sr_next    = sr_reg;
      pay_next   = pay_reg;
      sum_next   = sum_reg;
      miss_next  = miss_reg;
      lock_next  = lock_reg;
      err_next   = err_reg;
      dout_next  = dout_reg;
      dv_next    = 1'b0;
      bit_v      = 1'b0;
      hit_v      = 1'b0;

      if (sym_valid) begin
         for (int b = 0; b < 2; b++) begin
            bit_v = (b == 0) ? sym_i : sym_q;
            unique case (state_next)
               HUNT: begin
                  // The window flags assume HUNT held for the whole dibit; if
                  // HUNT was entered on the I bit the history was just cleared,
                  // so the Q-bit window is formed from the live history.
                  if (b == 0)
                     hit_v = odd_match;
                  else if (state_reg == HUNT)
                     hit_v = even_match;
                  else
                     hit_v = ({sr_next[6:0], bit_v} == HEADER);
                  sr_next = {sr_next[6:0], bit_v};
                  if (hit_v) begin
                     state_next = PAYLOAD;
                     cnt_next   = '0;
                     sum_next   = '0;
                  end
               end
               PAYLOAD: begin
                  pay_next = {pay_next[PAY_BITS-2:0], bit_v};
                  sr_next  = {sr_next[6:0], bit_v};
                  cnt_next = cnt_next + 1'b1;
                  // Fold each byte into the checksum as soon as it completes.
                  if (cnt_next[2:0] == 3'd0)
                     sum_next = sum_next + sr_next;
                  if (cnt_next == PAY_LAST) begin
                     state_next = CHKSUM;
                     cnt_next   = '0;
                  end
               end
               CHKSUM: begin
                  sr_next  = {sr_next[6:0], bit_v};
                  cnt_next = cnt_next + 1'b1;
                  if (cnt_next == BYTE_LAST) begin
                     cnt_next = '0;
                     if (sr_next == sum_next) begin
                        dout_next  = pay_next;
                        dv_next    = 1'b1;
                        lock_next  = 1'b1;
                        miss_next  = '0;
                        state_next = HDR_SLOT;
                     end else begin
                        err_next = sat_inc8(err_next);
                        if (lock_next) begin
                           state_next = HDR_SLOT;
                        end else begin
                           state_next = HUNT;
                           sr_next    = '0;
                        end
                     end
                  end
               end
               HDR_SLOT: begin
                  sr_next  = {sr_next[6:0], bit_v};
                  cnt_next = cnt_next + 1'b1;
                  if (cnt_next == BYTE_LAST) begin
                     cnt_next = '0;
                     sum_next = '0;
                     if (sr_next == HEADER) begin
                        miss_next  = '0;
                        state_next = PAYLOAD;
                     end else begin
                        err_next  = sat_inc8(err_next);
                        miss_next = miss_next + 4'd1;
                        if (miss_next >= MISS_LIM) begin
                           lock_next  = 1'b0;
                           miss_next  = '0;
                           sr_next    = '0;
                           state_next = HUNT;
                        end else begin
                           // Flywheel: trust the expected alignment.
                           state_next = PAYLOAD;
                        end
                     end
                  end
               end
               default: begin
                  state_next = HUNT;
               end
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= HUNT;
         cnt_reg   <= '0;
         sr_reg    <= '0;
         pay_reg   <= '0;
         sum_reg   <= '0;
         miss_reg  <= '0;
         lock_reg  <= 1'b0;
         err_reg   <= '0;
         dout_reg  <= '0;
         dv_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sr_reg    <= sr_next;
         pay_reg   <= pay_next;
         sum_reg   <= sum_next;
         miss_reg  <= miss_next;
         lock_reg  <= lock_next;
         err_reg   <= err_next;
         dout_reg  <= dout_next;
         dv_reg    <= dv_next;
      end
   end

   assign data_out   = dout_reg;
   assign data_valid = dv_reg;
   assign locked     = lock_reg;
   assign err_cnt    = err_reg;

endmodule

// File: tb/tb_qpsk_deframer.sv
// Scoreboard bench for qpsk_deframer: stimulus pushes expected payloads into a
// queue, an independent monitor pops and compares on every data_valid pulse.
module tb_qpsk_deframer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sym_valid;
   logic        sym_i;
   logic        sym_q;
   logic [23:0] data_out;
   logic        data_valid;
   logic        locked;
   logic [7:0]  err_cnt;

   int          tests = 0;
   int          fails = 0;
   logic [23:0] exp_q[$];
   logic        bitq[$];

   always #5 clk = ~clk;

   qpsk_deframer #(
      .HEADER        (8'hCC),
      .PAYLOAD_BYTES (3),
      .MISS_MAX      (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sym_valid  (sym_valid),
      .sym_i      (sym_i),
      .sym_q      (sym_q),
      .data_out   (data_out),
      .data_valid (data_valid),
      .locked     (locked),
      .err_cnt    (err_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", name, act);
      end
   endtask

   // Monitor: every data_valid pulse must match the oldest expected payload.
   initial begin
      forever begin
         @(negedge clk);
         if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_valid: got data_out %h expected no pulse", data_out);
            end else begin
               chk("sb_data_out", {8'h00, data_out}, {8'h00, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
   endtask

   task automatic push_frame(input logic [7:0] h, input logic [23:0] p, input logic [7:0] c);
      push_byte(h);
      push_byte(p[23:16]);
      push_byte(p[15:8]);
      push_byte(p[7:0]);
      push_byte(c);
   endtask

   // Send queued bits as dibits, optionally with random idle gaps.
   task automatic flush(input int max_gap);
      int gap;
      if (bitq.size() % 2 == 1) bitq.push_back(1'b0);
      while (bitq.size() >= 2) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gap) begin
            @(negedge clk);
            sym_valid = 1'b0;
         end
         @(negedge clk);
         sym_valid = 1'b1;
         sym_i     = bitq.pop_front();
         sym_q     = bitq.pop_front();
      end
      @(negedge clk);
      sym_valid = 1'b0;
      sym_i     = 1'b0;
      sym_q     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_rst_data_out"}, {8'h00, data_out}, 32'h0);
      chk({tag, "_rst_valid"},    {31'h0, data_valid}, 32'h0);
      chk({tag, "_rst_locked"},   {31'h0, locked}, 32'h0);
      chk({tag, "_rst_err"},      {24'h0, err_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      sym_valid = 1'b0;
      sym_i     = 1'b0;
      sym_q     = 1'b0;
      idle(2);

      // 1: clean aligned stream, three frames
      do_reset("s1");
      exp_q.push_back(24'h123456);
      push_frame(8'hCC, 24'h123456, 8'h9C);
      flush(0);
      idle(3);
      chk("s1_locked_first", {31'h0, locked}, 32'h1);
      repeat (2) begin
         exp_q.push_back(24'h123456);
         push_frame(8'hCC, 24'h123456, 8'h9C);
      end
      flush(0);
      idle(3);
      chk("s1_locked", {31'h0, locked}, 32'h1);
      chk("s1_err", {24'h0, err_cnt}, 32'h0);
      chk("s1_data_out", {8'h00, data_out}, 32'h123456);
      chk("s1_sb_empty", exp_q.size(), 32'h0);

      // 2: one junk bit, header found on the odd window
      do_reset("s2");
      bitq.push_back(1'b1);
      exp_q.push_back(24'h123456);
      push_frame(8'hCC, 24'h123456, 8'h9C);
      flush(0);
      idle(3);
      chk("s2_locked", {31'h0, locked}, 32'h1);
      chk("s2_data_out", {8'h00, data_out}, 32'h123456);
      chk("s2_err", {24'h0, err_cnt}, 32'h0);
      chk("s2_sb_empty", exp_q.size(), 32'h0);

      // 3: bad checksum while unlocked, then a good frame locks
      do_reset("s3");
      push_frame(8'hCC, 24'h123456, 8'h9D);
      flush(0);
      idle(3);
      chk("s3_bad_err", {24'h0, err_cnt}, 32'h1);
      chk("s3_bad_locked", {31'h0, locked}, 32'h0);
      chk("s3_bad_data_out", {8'h00, data_out}, 32'h0);
      exp_q.push_back(24'h123456);
      push_frame(8'hCC, 24'h123456, 8'h9C);
      flush(0);
      idle(3);
      chk("s3_good_locked", {31'h0, locked}, 32'h1);
      chk("s3_good_data_out", {8'h00, data_out}, 32'h123456);
      chk("s3_good_err", {24'h0, err_cnt}, 32'h1);

      // 4: flywheel over a corrupted header, then lose lock on the third miss
      exp_q.push_back(24'hABCDEF);
      push_frame(8'hCD, 24'hABCDEF, 8'h67);
      flush(0);
      idle(3);
      chk("s4_fly_err", {24'h0, err_cnt}, 32'h2);
      chk("s4_fly_locked", {31'h0, locked}, 32'h1);
      chk("s4_fly_data_out", {8'h00, data_out}, 32'hABCDEF);
      push_frame(8'h00, 24'h000000, 8'hFF);
      push_frame(8'h00, 24'h000000, 8'hFF);
      flush(0);
      idle(3);
      chk("s4_two_miss_locked", {31'h0, locked}, 32'h1);
      chk("s4_two_miss_err", {24'h0, err_cnt}, 32'h6);
      push_byte(8'h00);
      flush(0);
      idle(3);
      chk("s4_third_miss_locked", {31'h0, locked}, 32'h0);
      chk("s4_third_miss_err", {24'h0, err_cnt}, 32'h7);
      chk("s4_held_data_out", {8'h00, data_out}, 32'hABCDEF);

      // 5: reset mid-payload after a lock, then relock
      do_reset("s5a");
      exp_q.push_back(24'h123456);
      push_frame(8'hCC, 24'h123456, 8'h9C);
      flush(0);
      idle(3);
      chk("s5_pre_locked", {31'h0, locked}, 32'h1);
      push_byte(8'hCC);
      push_byte(8'h12);
      flush(0);
      do_reset("s5b");
      exp_q.push_back(24'h123456);
      push_frame(8'hCC, 24'h123456, 8'h9C);
      flush(0);
      idle(3);
      chk("s5_relock", {31'h0, locked}, 32'h1);
      chk("s5_data_out", {8'h00, data_out}, 32'h123456);

      // 6: scenario 1 with random idle gaps between dibits
      do_reset("s6");
      repeat (3) begin
         exp_q.push_back(24'h123456);
         push_frame(8'hCC, 24'h123456, 8'h9C);
      end
      flush(20);
      idle(3);
      chk("s6_locked", {31'h0, locked}, 32'h1);
      chk("s6_err", {24'h0, err_cnt}, 32'h0);
      chk("s6_data_out", {8'h00, data_out}, 32'h123456);

      chk("final_sb_empty", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
